// File: rtl/csr_regfile.sv
// Machine-mode CSR file: mstatus, mtvec, mscratch, mepc, mcause, mtval.
// Define CSR_COUNTER_EN to add the 64-bit mcycle/minstret counters.
`ifndef XLEN
`define XLEN 32
`endif

module csr_regfile (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [11:0]      csr_raddr_i,
  output logic [`XLEN-1:0] csr_rdata_o,
  output logic             csr_illegal_o,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_waddr_i,
  input  logic [`XLEN-1:0] csr_wdata_i,
  input  logic             trap_i,
  input  logic [`XLEN-1:0] trap_pc_i,
  input  logic [`XLEN-1:0] trap_cause_i,
  input  logic [`XLEN-1:0] trap_val_i,
  input  logic             mret_i,
  input  logic             instret_i,
  output logic [`XLEN-1:0] mtvec_o,
  output logic [`XLEN-1:0] mepc_o,
  output logic             mie_o
);
  localparam int XL = `XLEN;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;

  logic          mie_q, mie_d;
  logic          mpie_q, mpie_d;
  logic [XL-1:2] mtvec_q, mtvec_d;
  logic [XL-1:2] mepc_q, mepc_d;
  logic [XL-1:0] mscratch_q, mscratch_d;
  logic [XL-1:0] mcause_q, mcause_d;
  logic [XL-1:0] mtval_q, mtval_d;
  logic [XL-1:0] mstatus_rd;
  logic [1:0]    unused_pc_lo;

  assign unused_pc_lo = trap_pc_i[1:0];

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (csr_we_i) begin
      case (csr_waddr_i)
        A_MSTATUS: begin
          mie_d  = csr_wdata_i[3];
          mpie_d = csr_wdata_i[7];
        end
        A_MTVEC:    mtvec_d    = csr_wdata_i[XL-1:2];
        A_MSCRATCH: mscratch_d = csr_wdata_i;
        A_MEPC:     mepc_d     = csr_wdata_i[XL-1:2];
        A_MCAUSE:   mcause_d   = csr_wdata_i;
        A_MTVAL:    mtval_d    = csr_wdata_i;
        default: ;
      endcase
    end
    // Trap/mret assignments come last so they override CSR writes
    if (trap_i) begin
      mepc_d   = trap_pc_i[XL-1:2];
      mcause_d = trap_cause_i;
      mtval_d  = trap_val_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTER_EN
  localparam int CW = 2 * XL;
  logic [CW-1:0] mcycle_q, mcycle_d;
  logic [CW-1:0] minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q + CW'(1);
    minstret_d = instret_i ? minstret_q + CW'(1) : minstret_q;
    if (csr_we_i) begin
      case (csr_waddr_i)
        12'hB00: mcycle_d   = {mcycle_q[CW-1:XL], csr_wdata_i};
        12'hB80: mcycle_d   = {csr_wdata_i, mcycle_q[XL-1:0]};
        12'hB02: minstret_d = {minstret_q[CW-1:XL], csr_wdata_i};
        12'hB82: minstret_d = {csr_wdata_i, minstret_q[XL-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      A_MSTATUS:  csr_rdata_o = mstatus_rd;
      A_MTVEC:    csr_rdata_o = {mtvec_q, 2'b00};
      A_MSCRATCH: csr_rdata_o = mscratch_q;
      A_MEPC:     csr_rdata_o = {mepc_q, 2'b00};
      A_MCAUSE:   csr_rdata_o = mcause_q;
      A_MTVAL:    csr_rdata_o = mtval_q;
`ifdef CSR_COUNTER_EN
      12'hB00: csr_rdata_o = mcycle_q[XL-1:0];
      12'hB80: csr_rdata_o = mcycle_q[CW-1:XL];
      12'hB02: csr_rdata_o = minstret_q[XL-1:0];
      12'hB82: csr_rdata_o = minstret_q[CW-1:XL];
`endif
      default: csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o = {mtvec_q, 2'b00};
  assign mepc_o  = {mepc_q, 2'b00};
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed vector table, corner sequences,
// and random traffic against an address-indexed reference model.
module tb_csr_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] raddr = '0;
  logic [31:0] rdata;
  logic        illegal;
  logic        we = 1'b0;
  logic [11:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        trap = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] cause = '0;
  logic [31:0] tval = '0;
  logic        mret = 1'b0;
  logic        instret = 1'b0;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;

  csr_regfile dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .csr_raddr_i(raddr), .csr_rdata_o(rdata),
    .csr_illegal_o(illegal),
    .csr_we_i(we), .csr_waddr_i(waddr),
    .csr_wdata_i(wdata),
    .trap_i(trap), .trap_pc_i(pc),
    .trap_cause_i(cause), .trap_val_i(tval),
    .mret_i(mret), .instret_i(instret),
    .mtvec_o(mtvec), .mepc_o(mepc), .mie_o(mie)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: architectural value per CSR address
  bit [31:0] mdl [0:4095];
  bit        legal [0:4095];
  bit [63:0] mcyc, mins;

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic bit [31:0] wmask(input bit [11:0] a);
    case (a)
      12'h300:          return 32'h0000_0088;
      12'h305, 12'h341: return 32'hFFFF_FFFC;
      default:          return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4096; i++) mdl[i] = '0;
    mcyc = '0;
    mins = '0;
  endfunction

  function automatic bit [31:0] mdl_read(input bit [11:0] a);
    bit [31:0] r;
    r = '0;
    if (legal[a]) r = mdl[a] | ((a == 12'h300) ? 32'h1800 : 32'h0);
`ifdef CSR_COUNTER_EN
    case (a)
      12'hB00: r = mcyc[31:0];
      12'hB80: r = mcyc[63:32];
      12'hB02: r = mins[31:0];
      12'hB82: r = mins[63:32];
      default: ;
    endcase
`endif
    return r;
  endfunction

  function automatic void model_edge();
    bit [31:0] ms;
    bit hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ms = mdl[12'h300];
    if (trap)
      hit = waddr inside {12'h300, 12'h341, 12'h342, 12'h343};
    else
      hit = mret && (waddr == 12'h300);
    if (we && legal[waddr] && !hit)
      mdl[waddr] = wdata & wmask(waddr);
    if (trap) begin
      mdl[12'h341] = pc & 32'hFFFF_FFFC;
      mdl[12'h342] = cause;
      mdl[12'h343] = tval;
      mdl[12'h300] = ms[3] ? 32'h80 : 32'h0;
    end else if (mret) begin
      mdl[12'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
    end
`ifdef CSR_COUNTER_EN
    if (we && waddr == 12'hB00) mcyc[31:0] = wdata;
    else if (we && waddr == 12'hB80) mcyc[63:32] = wdata;
    else mcyc = mcyc + 64'd1;
    if (we && waddr == 12'hB02) mins[31:0] = wdata;
    else if (we && waddr == 12'hB82) mins[63:32] = wdata;
    else if (instret) mins = mins + 64'd1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0;
    trap = 1'b0;
    mret = 1'b0;
    instret = 1'b0;
  endtask

  typedef struct {
    bit        we;
    bit [11:0] waddr;
    bit [31:0] wdata;
    bit        trap;
    bit [31:0] pc;
    bit [31:0] cause;
    bit [31:0] tval;
    bit        mret;
    bit [11:0] raddr;
    bit [31:0] exp;
    bit        ill;
  } vec_t;

  vec_t tbl [14];
  bit [11:0] addrs [13];
  bit [11:0] base [6];

  initial begin
    for (int i = 0; i < 4096; i++) legal[i] = 1'b0;
    legal[12'h300] = 1'b1; legal[12'h305] = 1'b1;
    legal[12'h340] = 1'b1; legal[12'h341] = 1'b1;
    legal[12'h342] = 1'b1; legal[12'h343] = 1'b1;
`ifdef CSR_COUNTER_EN
    legal[12'hB00] = 1'b1; legal[12'hB80] = 1'b1;
    legal[12'hB02] = 1'b1; legal[12'hB82] = 1'b1;
`endif
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h343, 12'hB00, 12'hB80,
              12'hB02, 12'hB82, 12'h7C0, 12'h000,
              12'hFFF};
    base = '{12'h300, 12'h305, 12'h340,
             12'h341, 12'h342, 12'h343};

    // we waddr wdata trap pc cause tval mret raddr exp ill
    tbl[0]  = '{1, 12'h305, 32'h8000_0103, 0, 0, 0, 0, 0,
                12'h305, 32'h8000_0100, 0};
    tbl[1]  = '{1, 12'h300, 32'h8, 0, 0, 0, 0, 0,
                12'h300, 32'h1808, 0};
    tbl[2]  = '{0, 12'h0, 32'h0, 1, 32'h1006, 32'hB, 32'h77, 0,
                12'h341, 32'h1004, 0};
    tbl[3]  = '{0, 12'h0, 32'h0, 0, 0, 0, 0, 0,
                12'h342, 32'hB, 0};
    tbl[4]  = '{0, 12'h0, 32'h0, 0, 0, 0, 0, 0,
                12'h300, 32'h1880, 0};
    tbl[5]  = '{0, 12'h0, 32'h0, 0, 0, 0, 0, 0,
                12'h343, 32'h77, 0};
    tbl[6]  = '{0, 12'h0, 32'h0, 0, 0, 0, 0, 1,
                12'h300, 32'h1888, 0};
    tbl[7]  = '{1, 12'h341, 32'h200, 1, 32'h2003, 32'h2, 32'h0, 0,
                12'h341, 32'h2000, 0};
    tbl[8]  = '{1, 12'h340, 32'h55, 1, 32'h3000, 32'h3, 32'h0, 0,
                12'h340, 32'h55, 0};
    tbl[9]  = '{1, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                12'h7C0, 32'h0, 1};
    tbl[10] = '{0, 12'h0, 32'h0, 0, 0, 0, 0, 0,
                12'h341, 32'h3000, 0};
    tbl[11] = '{1, 12'h300, 32'h0, 0, 0, 0, 0, 1,
                12'h300, 32'h1880, 0};
    tbl[12] = '{1, 12'h341, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                12'h341, 32'hFFFF_FFFC, 0};
    tbl[13] = '{1, 12'h300, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                12'h300, 32'h1888, 0};

    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // State straight out of reset
    foreach (base[i]) begin
      raddr = base[i];
      #1;
      check($sformatf("reset_rd_%h", base[i]), rdata,
            (base[i] == 12'h300) ? 32'h1800 : 32'h0);
    end
    check("reset_mtvec_o", mtvec, 32'h0);
    check("reset_mepc_o", mepc, 32'h0);
    check("reset_mie_o", {31'h0, mie}, 32'h0);
    @(negedge clk);

    foreach (tbl[i]) begin
      we = tbl[i].we;
      waddr = tbl[i].waddr;
      wdata = tbl[i].wdata;
      trap = tbl[i].trap;
      pc = tbl[i].pc;
      cause = tbl[i].cause;
      tval = tbl[i].tval;
      mret = tbl[i].mret;
      tick();
      idle();
      raddr = tbl[i].raddr;
      #1;
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
      check($sformatf("tbl%0d_illegal", i),
            {31'h0, illegal}, {31'h0, tbl[i].ill});
      if (i == 0) check("tbl0_mtvec_o", mtvec, 32'h8000_0100);
      @(negedge clk);
    end

`ifdef CSR_COUNTER_EN
    we = 1'b1; waddr = 12'hB00; wdata = 32'hFFFF_FFFF;
    tick();
    waddr = 12'hB80; wdata = 32'h0;
    tick();
    idle();
    raddr = 12'hB00;
    #1 check("mcycle_write_hold", rdata, 32'hFFFF_FFFF);
    tick();
    raddr = 12'hB80;
    #1 check("mcycle_carry_hi", rdata, 32'h1);
    raddr = 12'hB00;
    #1 check("mcycle_carry_lo", rdata, 32'h0);
    @(negedge clk);
    we = 1'b1; waddr = 12'hB00; wdata = 32'hFFFF_FFFF;
    tick();
    waddr = 12'hB80;
    tick();
    idle();
    raddr = 12'hB80;
    #1 check("mcycle_ones_hi", rdata, 32'hFFFF_FFFF);
    tick();
    #1 check("mcycle_wrap_hi", rdata, 32'h0);
    raddr = 12'hB00;
    #1 check("mcycle_wrap_lo", rdata, 32'h0);
    @(negedge clk);
    we = 1'b1; waddr = 12'hB02; wdata = 32'h5; instret = 1'b1;
    tick();
    we = 1'b0;
    raddr = 12'hB02;
    #1 check("minstret_write_hold", rdata, 32'h5);
    tick();
    idle();
    #1 check("minstret_inc", rdata, 32'h6);
    tick();
    #1 check("minstret_idle", rdata, 32'h6);
    @(negedge clk);
`else
    raddr = 12'hB00;
    #1 check("nocnt_mcycle_rd", rdata, 32'h0);
    check("nocnt_mcycle_ill", {31'h0, illegal}, 32'h1);
    raddr = 12'hB82;
    #1 check("nocnt_minstreth_ill", {31'h0, illegal}, 32'h1);
    @(negedge clk);
`endif

    // Asynchronous reset between edges
    we = 1'b1; waddr = 12'h340; wdata = 32'h1234;
    tick();
    idle();
    raddr = 12'h340;
    #1 check("mscratch_pre_rst", rdata, 32'h1234);
    rst_n = 1'b0;
    model_reset();
    #1 check("mscratch_async_rst", rdata, 32'h0);
    check("mtvec_async_rst", mtvec, 32'h0);
    tick();
    rst_n = 1'b1;

    // Reset held across an edge carrying a trap and a write
    trap = 1'b1; pc = 32'h5002; cause = 32'h7; tval = 32'h9;
    we = 1'b1; waddr = 12'h340; wdata = 32'h99;
    #1 rst_n = 1'b0;
    model_reset();
    tick();
    #1 check("rst_drop_mepc", mepc, 32'h0);
    check("rst_drop_mscratch", rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    idle();
    #1 check("post_rst_mepc", mepc, 32'h5000);
    check("post_rst_mscratch", rdata, 32'h99);
    raddr = 12'h342;
    #1 check("post_rst_mcause", rdata, 32'h7);
    @(negedge clk);

    for (int k = 0; k < 1500; k++) begin
      we = 1'($urandom_range(0, 1));
      waddr = addrs[$urandom_range(0, 12)];
      wdata = $urandom;
      trap = ($urandom_range(0, 7) == 0);
      pc = $urandom;
      cause = $urandom;
      tval = $urandom;
      mret = ($urandom_range(0, 7) == 0);
      instret = 1'($urandom_range(0, 1));
      raddr = addrs[$urandom_range(0, 12)];
      #1;
      check($sformatf("rnd%0d_rd_%h", k, raddr), rdata,
            mdl_read(raddr));
      check($sformatf("rnd%0d_ill", k), {31'h0, illegal},
            {31'h0, !legal[raddr]});
      check($sformatf("rnd%0d_mtvec_o", k), mtvec, mdl[12'h305]);
      check($sformatf("rnd%0d_mepc_o", k), mepc, mdl[12'h341]);
      check($sformatf("rnd%0d_mie_o", k), {31'h0, mie},
            {31'h0, mdl[12'h300][3]});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port csr_raddr_i, input, 12, CSR read address.
REQ-004 SHALL have port csr_rdata_o, output, `XLEN (32), combinational read data (old value, feeds the write-data generator).
REQ-005 SHALL have port csr_illegal_o, output, 1, high when csr_raddr_i is unimplemented.
REQ-006 SHALL have port csr_we_i, input, 1, CSR write enable.
REQ-007 SHALL have port csr_waddr_i, input, 12, CSR write address.
REQ-008 SHALL have port csr_wdata_i, input, `XLEN, final write value (already RW/RS/RC-resolved).
REQ-009 SHALL have ports trap_i (1), trap_pc_i (`XLEN), trap_cause_i (`XLEN), trap_val_i (`XLEN), inputs, trap entry request and its info.
REQ-010 SHALL have port mret_i, input, 1, trap return.
REQ-011 SHALL have port instret_i, input, 1, one instruction retired this cycle.
REQ-012 SHALL have outputs mtvec_o, mepc_o (`XLEN each) and mie_o (1), current register values.

Function
REQ-013 SHALL implement: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
REQ-014 mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-015 mtvec[1:0] and mepc[1:0] SHALL read 0 regardless of written value (direct mode, aligned).
REQ-016 Read SHALL be combinational, zero latency; unimplemented address -> csr_rdata_o=0, csr_illegal_o=1.
REQ-017 Write SHALL take effect on the clock edge where csr_we_i=1; visible on read the next cycle; unimplemented write address ignored.
REQ-018 trap_i=1: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_val_i, MPIE<=MIE, MIE<=0, all in one edge.
REQ-019 mret_i=1 (no trap): MIE<=MPIE, MPIE<=1.
REQ-020 Priority same cycle: trap_i > mret_i > csr_we_i; lower-priority updates to registers touched by the winner are dropped; csr_we_i to untouched registers (e.g. mscratch) still applies.
REQ-021 Outputs mtvec_o, mepc_o, mie_o SHALL reflect registered state (no bypass of same-cycle writes).

Reset
REQ-022 rst_n_i low SHALL clear all registers to 0 immediately, independent of clk_i: mstatus MIE=MPIE=0, mtvec_o=0, mepc_o=0, mie_o=0, counters 0.
REQ-023 Reset asserted mid-trap or mid-write SHALL discard the update; first edge after deassertion behaves normally.

Configuration
REQ-024 Macro CSR_COUNTER_EN, when defined, SHALL add 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02 low, 0xB82 high).
REQ-025 With CSR_COUNTER_EN: mcycle +1 every cycle; minstret +1 when instret_i=1; carry from low to high; 64-bit all-ones wraps to 0.
REQ-026 With CSR_COUNTER_EN: write to a counter half loads that half with csr_wdata_i, other half unchanged, and suppresses that counter's increment for that cycle.
REQ-027 Without CSR_COUNTER_EN: counter addresses are unimplemented (read 0, csr_illegal_o=1); instret_i ignored; no counter flops.

Verification
REQ-028 Write mtvec=0x8000_0103 -> next cycle read 0x305 = 0x8000_0100, mtvec_o=0x8000_0100.
REQ-029 Set MIE=1, trap_i with pc=0x0000_1006, cause=0xB -> mepc=0x0000_1004, mcause=0xB, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
REQ-030 Same cycle trap_i and csr_we_i to mepc=0x200 -> mepc=trap_pc_i&~3; same cycle trap_i and write mscratch=0x55 -> mscratch=0x55.
REQ-031 Read 0x7C0 -> csr_rdata_o=0, csr_illegal_o=1; write 0x7C0 -> no register changes.
REQ-032 CSR_COUNTER_EN: write mcycle low=0xFFFF_FFFF, high=0 -> two cycles later mcycleh=1, mcycle low=0; write cycle holds no increment.
REQ-033 Assert rst_n_i low between edges after writing mscratch=0x1234 -> mscratch reads 0 immediately, before next clk_i edge.
